// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter fed from the core store bus
//
// Snoops the store bus. A store to TX_ADDR queues writedata[7:0] in a small
// FIFO. A store to TX_ADDR+4 with writedata[0] set clears the sticky overflow
// flag. An 8N1 serializer drains the FIFO onto txd, LSB first.
//
// Parameters:
//   CLKS_PER_BIT - clock cycles per serial bit (>= 2)
//   DEPTH        - FIFO entries (power of two, 2..128)
//   TX_ADDR      - data register address; control register at TX_ADDR+4
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - synchronous, active-high
//   memwrite   - store strobe
//   dataadr    - store address
//   writedata  - store data ([7:0] data, [0] control)
//   txd        - registered serial output, idle high
//   busy       - frame in progress or bytes queued
//   fifo_full  - FIFO holds DEPTH bytes
//   overflow   - sticky, set when a byte is dropped
//   status     - {16'b0, count, 5'b0, overflow, fifo_full, busy}

module mmio_uart_tx #(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          DEPTH        = 8,
    parameter logic [31:0] TX_ADDR      = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic        txd,
    output logic        busy,
    output logic        fifo_full,
    output logic        overflow,
    output logic [31:0] status
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);

    localparam logic [AW:0]   COUNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] BAUD_LAST  = CW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // FIFO storage and bookkeeping
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    head;

    // Serializer
    logic [1:0]    state;
    logic [CW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    // Bus decode and handshake between FIFO and serializer
    logic push_req;
    logic push;
    logic pop;
    logic ctrl_clr;
    logic baud_done;
    logic fifo_empty;
    logic [7:0] count8;

    logic unused_bits;
    assign unused_bits = ^writedata[31:8];

    assign push_req   = memwrite && (dataadr == TX_ADDR);
    assign ctrl_clr   = memwrite && (dataadr == TX_ADDR + 32'd4) && writedata[0];
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == COUNT_FULL);

    // The full test uses the pre-pop count, so a full FIFO drops the byte even
    // when the serializer pops on the same edge.
    assign push = push_req && !fifo_full;

    assign baud_done = (baud == BAUD_LAST);

    // The serializer takes the head either from IDLE or at the very end of a
    // STOP bit, which gives back-to-back frames with no idle gap.
    assign pop = !fifo_empty &&
                 ((state == S_IDLE) || ((state == S_STOP) && baud_done));

    assign head = mem[rd_ptr];

    // Storage has no reset; validity is tracked by count and the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= writedata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A drop takes precedence over a clear on the same edge.
            if (push_req && !push) begin
                overflow <= 1'b1;
            end else if (ctrl_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    // txd is loaded with the level of the state being entered, so it is a
    // pure register with no path from the bus.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            baud    <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'd0;
            txd     <= 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    baud <= '0;
                    if (pop) begin
                        shift <= head;
                        state <= S_START;
                        txd   <= 1'b0;
                    end else begin
                        txd <= 1'b1;
                    end
                end

                S_START: begin
                    if (baud_done) begin
                        baud    <= '0;
                        bit_idx <= 3'd0;
                        state   <= S_DATA;
                        txd     <= shift[0];
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end

                S_DATA: begin
                    if (baud_done) begin
                        baud  <= '0;
                        shift <= {1'b0, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                            txd   <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            txd     <= shift[1];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end

                S_STOP: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (pop) begin
                            shift <= head;
                            state <= S_START;
                            txd   <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                            txd   <= 1'b1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    baud  <= '0;
                    txd   <= 1'b1;
                end
            endcase
        end
    end

    assign busy   = (state != S_IDLE) || !fifo_empty;
    assign count8 = 8'(count);
    assign status = {16'h0000, count8, 5'b00000, overflow, fifo_full, busy};

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - self-checking bench for mmio_uart_tx with frame-level reference model

module tb_mmio_uart_tx;

    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] A     = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        txd;
    logic        busy;
    logic        fifo_full;
    logic        overflow;
    logic [31:0] status;

    int n_checks = 0;
    int n_errors = 0;

    mmio_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .DEPTH        (DEPTH),
        .TX_ADDR      (A)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .dataadr   (dataadr),
        .writedata (writedata),
        .txd       (txd),
        .busy      (busy),
        .fifo_full (fifo_full),
        .overflow  (overflow),
        .status    (status)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus "which frame is on the wire and how
    // many cycles into it". The line level is derived from the cycle offset.
    logic [7:0] mq[$];
    logic       m_valid = 1'b0;
    logic       m_active;
    int         m_pos;
    logic [7:0] m_byte;
    logic       m_ovf;
    int         m_pre;
    logic       m_start;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_active = 1'b0;
            m_pos    = 0;
            m_byte   = 8'h00;
            m_ovf    = 1'b0;
            m_valid  = 1'b1;
        end else if (m_valid) begin
            m_pre   = mq.size();
            m_start = 1'b0;
            if (!m_active) begin
                m_start = (m_pre > 0);
            end else if (m_pos == 10 * CPB - 1) begin
                if (m_pre > 0) m_start = 1'b1;
                else m_active = 1'b0;
            end else begin
                m_pos = m_pos + 1;
            end
            if (m_start) begin
                m_byte   = mq.pop_front();
                m_active = 1'b1;
                m_pos    = 0;
            end
            if (memwrite && dataadr == A) begin
                if (m_pre < DEPTH) mq.push_back(writedata[7:0]);
                else m_ovf = 1'b1;
            end else if (memwrite && dataadr == A + 32'd4 && writedata[0]) begin
                m_ovf = 1'b0;
            end
        end
    end

    function automatic logic exp_txd();
        int k;
        if (!m_active) return 1'b1;
        k = m_pos / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return m_byte[k-1];
    endfunction

    function automatic logic [31:0] exp_status();
        logic [7:0] c;
        logic       b;
        logic       f;
        c = 8'(mq.size());
        b = m_active || (mq.size() != 0);
        f = (mq.size() == DEPTH);
        return {16'h0000, c, 5'b00000, m_ovf, f, b};
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            logic [31:0] es;
            es = exp_status();
            check("model_txd", txd, exp_txd());
            check("model_busy", busy, es[0]);
            check("model_full", fifo_full, es[1]);
            check("model_ovf", overflow, es[2]);
            check("model_status", status, es);
        end
    end

    task automatic bus(input logic we, input logic [31:0] a, input logic [31:0] d);
        memwrite  = we;
        dataadr   = a;
        writedata = d;
        @(negedge clk);
    endtask

    task automatic wait_idle();
        memwrite = 1'b0;
        for (int k = 0; k < 2000 && busy; k++) @(negedge clk);
        check("idle_wait", busy, 1'b0);
    endtask

    int nb;
    int peak;
    logic [9:0] pat;

    task automatic sample_b2b();
        if (busy) nb++;
        if (int'(status[15:8]) > peak) peak = int'(status[15:8]);
    endtask

    initial begin
        reset     = 1'b1;
        memwrite  = 1'b0;
        dataadr   = 32'h0;
        writedata = 32'h0;

        // Reset values and quiet line
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_txd", txd, 1'b1);
        check("reset_status", status, 32'h0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("quiet_txd", txd, 1'b1);
        end

        // Single byte 0x55: start, 1,0,1,0,1,0,1,0, stop
        pat = 10'b1010101010;
        bus(1'b1, A, 32'h1234_5655);
        memwrite = 1'b0;
        check("single_status", status, 32'h0000_0101);
        for (int i = 0; i < 10 * CPB; i++) begin
            @(negedge clk);
            check("single_txd", txd, pat[i / CPB]);
            check("single_busy", busy, 1'b1);
        end
        @(negedge clk);
        check("single_busy_end", busy, 1'b0);
        check("single_txd_end", txd, 1'b1);

        // Back-to-back bytes
        wait_idle();
        nb   = 0;
        peak = 0;
        bus(1'b1, A, 32'hA5); sample_b2b();
        bus(1'b1, A, 32'h00); sample_b2b();
        bus(1'b1, A, 32'hFF); sample_b2b();
        memwrite = 1'b0;
        for (int i = 0; i < 300 && busy; i++) begin
            @(negedge clk);
            sample_b2b();
        end
        check("b2b_busy_cycles", nb, 121);
        check("b2b_peak", peak, 2);

        // Overflow
        wait_idle();
        for (int b = 1; b <= 6; b++) begin
            bus(1'b1, A, b);
            if (b == 5) begin
                check("ovf_full5", fifo_full, 1'b1);
                check("ovf_clear5", overflow, 1'b0);
            end
        end
        check("ovf_set6", overflow, 1'b1);
        memwrite = 1'b0;
        repeat (50) @(negedge clk);
        check("ovf_sticky", overflow, 1'b1);
        bus(1'b1, A + 32'd4, 32'h1);
        memwrite = 1'b0;
        check("ovf_cleared", overflow, 1'b0);

        // Ignored bus activity
        wait_idle();
        bus(1'b1, A + 32'd8, 32'h41);
        check("ign_status_a8", status, 32'h0);
        bus(1'b1, 32'h0000_0100, 32'h42);
        check("ign_status_100", status, 32'h0);
        bus(1'b0, A, 32'h43);
        check("ign_status_nowe", status, 32'h0);
        repeat (3) begin
            @(negedge clk);
            check("ign_txd", txd, 1'b1);
        end

        // Reset mid-frame
        bus(1'b1, A, 32'h3C);
        bus(1'b1, A, 32'hC3);
        bus(1'b1, A, 32'h81);
        memwrite = 1'b0;
        repeat (12) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_mid_txd", txd, 1'b1);
        check("rst_mid_status", status, 32'h0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("rst_mid_quiet", txd, 1'b1);
        end

        // Randomized bus traffic with occasional resets
        for (int i = 0; i < 4000; i++) begin
            int r;
            r         = int'($urandom_range(0, 99));
            reset     = ($urandom_range(0, 599) == 0);
            writedata = $urandom;
            if (r < 30) begin
                memwrite = 1'b1; dataadr = A;
            end else if (r < 35) begin
                memwrite = 1'b1; dataadr = A + 32'd4;
            end else if (r < 40) begin
                memwrite = 1'b1; dataadr = (r < 38) ? A + 32'd8 : 32'h0000_0100;
            end else if (r < 45) begin
                memwrite = 1'b0; dataadr = A;
            end else begin
                memwrite = 1'b0; dataadr = $urandom;
            end
            @(negedge clk);
        end
        reset = 1'b0;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
